// File: rtl/median_pkg.sv
// Shared types and helpers for the 3x3 median tile filter.
// Build option: MEDIAN_PIPE_EN adds a register after the column-sort stage (LAT = 3 instead of 2).
package median_pkg;

  localparam int PIX_W    = 8;
  localparam int IN_ROWS  = 5;
  localparam int IN_COLS  = 14;
  localparam int OUT_ROWS = IN_ROWS - 2;
  localparam int OUT_COLS = IN_COLS - 2;
`ifdef MEDIAN_PIPE_EN
  localparam int LAT      = 3;
`else
  localparam int LAT      = 2;
`endif

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    pix_t hi;
    pix_t mid;
    pix_t lo;
  } sort3_t;

  // Three compare-exchange steps; unsigned compare, ties keep the value as-is.
  function automatic sort3_t sort3(input pix_t a, input pix_t b, input pix_t c);
    pix_t s0, s1, s2, t;
    sort3_t r;
    s0 = a;
    s1 = b;
    s2 = c;
    if (s0 > s1) begin t = s0; s0 = s1; s1 = t; end
    if (s1 > s2) begin t = s1; s1 = s2; s2 = t; end
    if (s0 > s1) begin t = s0; s0 = s1; s1 = t; end
    r.lo  = s0;
    r.mid = s1;
    r.hi  = s2;
    return r;
  endfunction

endpackage

// File: rtl/median3x3_tile_median9.sv
// median9: exact median of a 3x3 neighbourhood using the column-sort method.
// pRC is the pixel at neighbourhood row R, column C.
// Build option: MEDIAN_PIPE_EN registers the sorted columns (adds clk/rst_n ports).
module median9
  import median_pkg::*;
(
`ifdef MEDIAN_PIPE_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  pix_t p00,
  input  pix_t p01,
  input  pix_t p02,
  input  pix_t p10,
  input  pix_t p11,
  input  pix_t p12,
  input  pix_t p20,
  input  pix_t p21,
  input  pix_t p22,
  output pix_t med
);

  sort3_t [2:0] col_d;
  sort3_t [2:0] col;
  sort3_t       lo_s, mid_s, hi_s, fin_s;

  // Sort each column independently.
  always_comb begin
    col_d[0] = sort3(p00, p10, p20);
    col_d[1] = sort3(p01, p11, p21);
    col_d[2] = sort3(p02, p12, p22);
  end

`ifdef MEDIAN_PIPE_EN
  sort3_t [2:0] col_q;

  // Optional pipeline register between column sort and the merge stage.
  always_ff @(posedge clk) begin
    if (rst_n) col_q <= '0;
    else       col_q <= col_d;
  end

  assign col = col_q;
`else
  assign col = col_d;
`endif

  // Max of minimums, median of middles, min of maximums, then median of those three.
  always_comb begin
    lo_s  = sort3(col[0].lo,  col[1].lo,  col[2].lo);
    mid_s = sort3(col[0].mid, col[1].mid, col[2].mid);
    hi_s  = sort3(col[0].hi,  col[1].hi,  col[2].hi);
    fin_s = sort3(lo_s.hi, mid_s.mid, hi_s.lo);
    med   = fin_s.mid;
  end

endmodule

// File: rtl/median3x3_tile.sv
// median3x3_tile: 5x14 window in, 3x12 block of 3x3 medians out, one block per clock.
// rst_n is active-high and synchronous despite its name.
// Build option: MEDIAN_PIPE_EN adds a stage inside each median unit (LAT = 3).
module median3x3_tile
  import median_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [PIX_W*IN_ROWS*IN_COLS-1:0]    pixel_in,
  output logic                                valid,
  output logic [PIX_W*OUT_ROWS*OUT_COLS-1:0]  pixel_out
);

  logic [PIX_W*IN_ROWS*IN_COLS-1:0]   pixel_in_d,  pixel_in_q;
  logic [PIX_W*OUT_ROWS*OUT_COLS-1:0] pixel_out_d, pixel_out_q;
  logic [LAT-1:0]                     vld_d, vld_q;

  pix_t win [IN_ROWS][IN_COLS];
  pix_t med [OUT_ROWS][OUT_COLS];

  // Next-state for input, output and valid shift registers.
  always_comb begin
    pixel_in_d = pixel_in;
    vld_d      = {vld_q[LAT-2:0], 1'b1};
    pixel_out_d = '0;
    for (int r = 0; r < OUT_ROWS; r++) begin
      for (int c = 0; c < OUT_COLS; c++) begin
        pixel_out_d[PIX_W*(OUT_ROWS*OUT_COLS-1-(OUT_COLS*r+c)) +: PIX_W] = med[r][c];
      end
    end
  end

  // Pipeline registers with synchronous active-high clear.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pixel_in_q  <= '0;
      pixel_out_q <= '0;
      vld_q       <= '0;
    end else begin
      pixel_in_q  <= pixel_in_d;
      pixel_out_q <= pixel_out_d;
      vld_q       <= vld_d;
    end
  end

  // Unpack the registered window; row 0 / col 0 sits in the top byte.
  always_comb begin
    for (int r = 0; r < IN_ROWS; r++) begin
      for (int c = 0; c < IN_COLS; c++) begin
        win[r][c] = pixel_in_q[PIX_W*(IN_ROWS*IN_COLS-1-(IN_COLS*r+c)) +: PIX_W];
      end
    end
  end

  for (genvar gr = 0; gr < OUT_ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < OUT_COLS; gc++) begin : g_col
      median9 u_med (
`ifdef MEDIAN_PIPE_EN
        .clk   (clk),
        .rst_n (rst_n),
`endif
        .p00 (win[gr][gc]),   .p01 (win[gr][gc+1]),   .p02 (win[gr][gc+2]),
        .p10 (win[gr+1][gc]), .p11 (win[gr+1][gc+1]), .p12 (win[gr+1][gc+2]),
        .p20 (win[gr+2][gc]), .p21 (win[gr+2][gc+1]), .p22 (win[gr+2][gc+2]),
        .med (med[gr][gc])
      );
    end
  end

  assign valid     = vld_q[LAT-1];
  assign pixel_out = pixel_out_q;

endmodule

// File: tb/tb_median3x3_tile.sv
// Self-checking bench for median3x3_tile (works with or without MEDIAN_PIPE_EN).
module tb_median3x3_tile;

`ifdef MEDIAN_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int IW = 560;
  localparam int OW = 288;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [IW-1:0] pixel_in = '0;
  logic          valid;
  logic [OW-1:0] pixel_out;

  int errors = 0;
  int checks = 0;
  logic [OW-1:0] exp_q [$];

  typedef struct {
    logic [IW-1:0] win;
    logic [OW-1:0] exp;
  } vec_t;
  vec_t tbl [$];

  median3x3_tile dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pixel_in  (pixel_in),
    .valid     (valid),
    .pixel_out (pixel_out)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] setp(logic [IW-1:0] w, int r, int c, logic [7:0] v);
    w[IW-1-8*(14*r+c) -: 8] = v;
    return w;
  endfunction

  function automatic logic [7:0] getp(logic [IW-1:0] w, int r, int c);
    return w[IW-1-8*(14*r+c) -: 8];
  endfunction

  function automatic logic [IW-1:0] flat(logic [7:0] v);
    logic [IW-1:0] w;
    for (int i = 0; i < 70; i++) w[8*i +: 8] = v;
    return w;
  endfunction

  function automatic logic [OW-1:0] flat_out(logic [7:0] v);
    logic [OW-1:0] o;
    for (int i = 0; i < 36; i++) o[8*i +: 8] = v;
    return o;
  endfunction

  // mode 0: full-range pixels; mode 1: values 0..3 (many ties); mode 2: salt-and-pepper on grey
  function automatic logic [IW-1:0] rnd_win(int mode);
    logic [IW-1:0] w;
    int k;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 14; c++) begin
        if (mode == 0) w = setp(w, r, c, 8'($urandom_range(0, 255)));
        else if (mode == 1) w = setp(w, r, c, 8'($urandom_range(0, 3)));
        else begin
          k = $urandom_range(0, 9);
          w = setp(w, r, c, (k == 0) ? 8'hFF : (k == 1) ? 8'h00 : 8'($urandom_range(100, 140)));
        end
      end
    end
    return w;
  endfunction

  // Reference: gather the 9 neighbours, sort them, take the 5th smallest.
  function automatic logic [OW-1:0] model(logic [IW-1:0] w);
    logic [OW-1:0] o;
    int v [9];
    int k, t;
    o = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 12; c++) begin
        k = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++) begin
            v[k] = int'(getp(w, r+dr, c+dc));
            k++;
          end
        for (int i = 1; i < 9; i++)
          for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
            t = v[j]; v[j] = v[j-1]; v[j-1] = t;
          end
        o[OW-1-8*(12*r+c) -: 8] = 8'(v[4]);
      end
    end
    return o;
  endfunction

  task automatic chk(string nm, logic [OW-1:0] act, logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // One streaming edge; results emerge LAT-1 steps after their window is applied.
  task automatic step(logic [IW-1:0] w, logic [OW-1:0] e);
    pixel_in = w;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    if (exp_q.size() > LAT-1) begin
      chk1("valid_stream", valid, 1'b1);
      chk("stream_out", pixel_out, exp_q.pop_front());
    end else begin
      chk1("valid_fill", valid, 1'b0);
    end
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (n) begin
      pixel_in = rnd_win(0);
      @(posedge clk);
      #1;
      chk1("rst_valid", valid, 1'b0);
      chk("rst_out", pixel_out, '0);
    end
    rst_n = 1'b0;
  endtask

  initial begin
    logic [IW-1:0] w;
    logic [7:0]    b;

    // Reset held for two edges with arbitrary input
    do_reset(2);

    // Directed table; consecutive entries also exercise back-to-back throughput
    tbl.push_back('{flat(8'h80), flat_out(8'h80)});
    tbl.push_back('{setp(flat(8'h00), 2, 6, 8'hFF), flat_out(8'h00)});
    tbl.push_back('{flat(8'hFF), flat_out(8'hFF)});
    w = '0;
    w = setp(w, 0, 0, 8'd9); w = setp(w, 0, 1, 8'd2); w = setp(w, 0, 2, 8'd7);
    w = setp(w, 1, 0, 8'd4); w = setp(w, 1, 1, 8'd5); w = setp(w, 1, 2, 8'd1);
    w = setp(w, 2, 0, 8'd8); w = setp(w, 2, 1, 8'd3); w = setp(w, 2, 2, 8'd6);
    tbl.push_back('{w, model(w)});
    tbl.push_back('{flat(8'h10), flat_out(8'h10)});
    tbl.push_back('{flat(8'h20), flat_out(8'h20)});
    tbl.push_back('{flat(8'h30), flat_out(8'h30)});
    tbl.push_back('{flat(8'h40), flat_out(8'h40)});
    foreach (tbl[i]) step(tbl[i].win, tbl[i].exp);

    // Randomised stream against the reference model
    for (int i = 0; i < 60; i++) begin
      w = rnd_win(i % 3);
      step(w, model(w));
    end

    // Ordering: hold the scrambled 1..9 window and check out(0,0) directly
    w = tbl[3].win;
    pixel_in = w;
    repeat (LAT) @(posedge clk);
    #1;
    b = pixel_out[OW-1 -: 8];
    checks++;
    if (b !== 8'h05) begin
      errors++;
      $display("FAIL order_00: got %h expected 05", b);
    end
    chk("order_full", pixel_out, model(w));
    chk1("order_valid", valid, 1'b1);

    // Mid-stream reset: one reset edge, then valid must return exactly LAT edges after release
    for (int i = 0; i < 5; i++) begin
      w = rnd_win(0);
      pixel_in = w;
      @(posedge clk);
    end
    #1;
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      w = rnd_win(i % 3);
      step(w, model(w));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
